// File: rtl/pe_rr_dispatcher_pkg.sv
// pe_dispatch_pkg: shared defaults, width helpers and reset constants for the PE dispatcher.
package pe_dispatch_pkg;
  localparam int DEF_NUM_PE  = 4;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MAX_OUT = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cred_w(input int m);
    return $clog2(m + 1);
  endfunction
  // rr_ptr resets to the last index so the first grant lands on PE0
  function automatic int rr_rst(input int n);
    return n - 1;
  endfunction
  function automatic int cred_rst(input int m);
    return m;
  endfunction
endpackage

// File: rtl/pe_rr_dispatcher_picker.sv
// rr_picker: combinational round-robin finder, first eligible index after ptr_i (wrapping).
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // scanning from the far offset down lets the nearest eligible index win
  always_comb begin
    idx_o = '0;
    for (int k = N; k >= 1; k--)
      if (elig_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
    any_o = |elig_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/pe_rr_dispatcher.sv
// pe_rr_dispatcher: credit-based round-robin steering of one FIFO stream onto NUM_PE PEs
// through a single registered output stage.
module pe_rr_dispatcher
  import pe_dispatch_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_fifo_valid,
  output logic              io_fifo_ready,
  input  logic [DATA_W-1:0] io_fifo_data,
  output logic [NUM_PE-1:0] io_pe_valid,
  input  logic [NUM_PE-1:0] io_pe_ready,
  output logic [DATA_W-1:0] io_pe_data,
  input  logic [NUM_PE-1:0] io_pe_done,
  output logic              io_idle,
  output logic              io_err
);
  localparam int IW = idx_w(NUM_PE);
  localparam int CW = cred_w(MAX_OUT);
  localparam logic [IW-1:0] RR_RST   = IW'(rr_rst(NUM_PE));
  localparam logic [CW-1:0] CRED_RST = CW'(cred_rst(MAX_OUT));
  logic              out_valid_q, err_q, fire, acc, pick_any;
  logic [DATA_W-1:0] out_data_q;
  logic [IW-1:0]     out_sel_q, rr_ptr_q, pick_idx;
  logic [CW-1:0]     credit_q [NUM_PE];
  logic [CW-1:0]     credit_d [NUM_PE];
  logic [NUM_PE-1:0] elig, at_max, pick_gnt;
  rr_picker #(.N(NUM_PE), .IW(IW)) u_pick (
    .elig_i(elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  // credits are spent at accept; a done at MAX_OUT is flagged and not counted
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      elig[i]     = credit_q[i] != '0;
      at_max[i]   = credit_q[i] == CRED_RST;
      credit_d[i] = credit_q[i] - CW'(acc & pick_gnt[i]) + CW'(io_pe_done[i] & ~at_max[i]);
    end
  end
  assign fire          = out_valid_q & io_pe_ready[out_sel_q];
  assign io_fifo_ready = reset & (~out_valid_q | fire) & pick_any;
  assign acc           = io_fifo_valid & io_fifo_ready;
  assign io_pe_valid   = out_valid_q ? NUM_PE'(1) << out_sel_q : '0;
  assign io_pe_data    = out_data_q;
  assign io_idle       = ~out_valid_q & (&at_max);
  assign io_err        = err_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= RR_RST;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) credit_q[i] <= CRED_RST;
    end else begin
      if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= io_fifo_data;
        out_sel_q   <= pick_idx;
        rr_ptr_q    <= pick_idx;
      end else if (fire) begin
        out_valid_q <= 1'b0;
      end
      credit_q <= credit_d;
      err_q    <= err_q | (|(io_pe_done & at_max));
    end
  end
endmodule

// File: tb/tb_pe_rr_dispatcher.sv
// tb_pe_rr_dispatcher: scoreboard bench; a job-count model predicts grants, a monitor checks deliveries.
module tb_pe_rr_dispatcher;
  localparam int NP = 4;
  localparam int MX = 2;
  logic clk, rst_n;
  logic fifo_valid, fifo_ready;
  logic [15:0] fifo_data, pe_data;
  logic [NP-1:0] pe_valid, pe_ready, pe_done;
  logic idle, err;
  typedef struct {int pe; logic [15:0] d;} item_t;
  item_t sb[$];
  int n_cmp = 0, n_fail = 0;
  int cred[NP];
  int last, hpe;
  bit busy, err_m;
  pe_rr_dispatcher #(.NUM_PE(NP), .DATA_W(16), .MAX_OUT(MX)) dut (
    .clock(clk), .reset(rst_n),
    .io_fifo_valid(fifo_valid), .io_fifo_ready(fifo_ready), .io_fifo_data(fifo_data),
    .io_pe_valid(pe_valid), .io_pe_ready(pe_ready), .io_pe_data(pe_data),
    .io_pe_done(pe_done), .io_idle(idle), .io_err(err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_idle();
    bit r = !busy;
    for (int i = 0; i < NP; i++) r &= cred[i] == MX;
    return r;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < NP; i++) cred[i] = MX;
    last = NP - 1; busy = 0; hpe = 0; err_m = 0;
    sb.delete();
  endtask
  // one cycle: drive at negedge, check predicted outputs, advance the model
  task automatic step(input bit v, input logic [15:0] d, input logic [NP-1:0] rdy, input logic [NP-1:0] dn);
    int c0[NP];
    bit fm, any, er;
    int tgt;
    @(negedge clk);
    fifo_valid = v; fifo_data = d; pe_ready = rdy; pe_done = dn;
    #1;
    fm = busy && rdy[hpe];
    any = 0;
    for (int i = 0; i < NP; i++) any |= cred[i] > 0;
    er = (!busy || fm) && any;
    chk("fifo_ready", int'(fifo_ready), int'(er));
    chk("pe_valid", int'(pe_valid), busy ? (1 << hpe) : 0);
    chk("idle", int'(idle), int'(m_idle()));
    chk("err", int'(err), int'(err_m));
    c0 = cred;
    if (v && er) begin
      tgt = -1;
      for (int k = 1; k <= NP; k++)
        if (tgt < 0 && cred[(last + k) % NP] > 0) tgt = (last + k) % NP;
      sb.push_back('{tgt, d});
      last = tgt; cred[tgt]--; busy = 1; hpe = tgt;
    end else if (fm) busy = 0;
    for (int i = 0; i < NP; i++)
      if (dn[i]) begin
        if (c0[i] == MX) err_m = 1;
        else cred[i]++;
      end
  endtask
  task automatic drain();
    logic [NP-1:0] m;
    for (int n = 0; n < 30 && !m_idle(); n++) begin
      m = '0;
      for (int i = 0; i < NP; i++) m[i] = cred[i] < MX;
      step(0, 16'h0, '1, m);
    end
    chk("drain_idle", int'(m_idle()), 1);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0; fifo_valid = 0; pe_ready = 0; pe_done = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask
  // monitor: every PE handshake must match the oldest predicted delivery
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && (pe_valid & pe_ready) != '0) begin
        if (sb.size() == 0) chk("unexpected_delivery", int'(pe_valid), 0);
        else begin
          it = sb.pop_front();
          chk("pe_sel", int'(pe_valid), 1 << it.pe);
          chk("pe_data", int'(pe_data), int'(it.d));
        end
      end
    end
  end
  initial begin
    logic [NP-1:0] m;
    rst_n = 0; fifo_valid = 0; fifo_data = 0; pe_ready = 0; pe_done = 0;
    m_reset();
    #12;
    chk("rst_fifo_ready", int'(fifo_ready), 0);
    chk("rst_pe_valid", int'(pe_valid), 0);
    chk("rst_pe_data", int'(pe_data), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1;
    // stream of 8 words exhausts every credit
    for (int i = 1; i <= 8; i++) step(1, 16'(i), '1, '0);
    step(1, 16'h9, '1, '0);
    // credit return on PE2 only
    step(1, 16'h9, '1, 4'b0100);
    step(1, 16'h9, '1, '0);
    step(1, 16'hA, '1, '0);
    step(1, 16'hA, '1, '0);
    step(1, 16'hA, '1, 4'b0001);
    step(1, 16'hA, '1, '0);
    step(0, 16'h0, '1, '0);
    drain();
    // backpressure on PE1
    reset_dut();
    step(1, 16'hA0, '1, '0);
    step(1, 16'hA1, 4'b1101, '0);
    repeat (5) step(1, 16'hA2, 4'b1101, '0);
    step(1, 16'hA2, '1, '0);
    step(1, 16'hA3, '1, '0);
    drain();
    // accept to PE0 coinciding with its done
    reset_dut();
    for (int i = 1; i <= 4; i++) step(1, 16'(16'h10 + i), '1, '0);
    step(1, 16'h15, '1, 4'b0001);
    step(1, 16'h16, '1, '0);
    step(1, 16'h17, '1, '0);
    drain();
    // spurious done at full credit
    step(0, 16'h0, '1, 4'b1000);
    repeat (3) step(0, 16'h0, '1, '0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      m = '0;
      for (int i = 0; i < NP; i++) m[i] = cred[i] < MX && $urandom_range(0, 3) == 0;
      step($urandom_range(0, 3) != 0, 16'($urandom), NP'($urandom), m);
    end
    drain();
    // async reset while PE2 holds a word
    reset_dut();
    step(1, 16'hB0, '1, '0);
    step(1, 16'hB1, '1, '0);
    step(1, 16'hB2, 4'b1011, '0);
    step(0, 16'h0, 4'b1011, '0);
    #2;
    rst_n = 0;
    #1;
    chk("async_pe_valid", int'(pe_valid), 0);
    chk("async_pe_data", int'(pe_data), 0);
    chk("async_fifo_ready", int'(fifo_ready), 0);
    chk("async_idle", int'(idle), 1);
    chk("async_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    step(1, 16'h55, '1, '0);
    step(0, 16'h0, '1, '0);
    drain();
    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
